// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array front end.
// Holds the feeder state encoding and the default drain counter width.
package tpu_pkg;

   typedef enum logic [1:0] {
      FEED_IDLE  = 2'd0,
      FEED_CLEAR = 2'd1,
      FEED_FEED  = 2'd2,
      FEED_DRAIN = 2'd3
   } feed_state_e;

   localparam int FEED_N  = 4;
   localparam int DRAIN_W = $clog2(2 * FEED_N);

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line: pushes data when din_vld, else zero; output is the last stage.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_vld,
   input  logic [WIDTH-1:0] din_dat,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din_vld ? din_dat : '0;
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A/B operand lanes into an NxN array and sequences clear/feed/drain/done per job.
// Lane i delayed i+1 cycles; in_ready is registered and high only in FEED (no path from in_valid).
module systolic_feeder
   import tpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N*WIDTH-1:0] in_a,
   input  logic [N*WIDTH-1:0] in_b,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             clear,
   output logic [N*WIDTH-1:0] a_edge,
   output logic [N*WIDTH-1:0] b_edge,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(2 * N);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(2 * N - 2);

   feed_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clear_q, clear_d;
   logic             done_q, done_d;
   logic             in_ready_q, in_ready_d;
   logic             accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         FEED_IDLE: begin
            if (start) state_d = FEED_CLEAR;
         end
         FEED_CLEAR: begin
            state_d = FEED_FEED;
         end
         FEED_FEED: begin
            if (accept && in_last) begin
               state_d = FEED_DRAIN;
               cnt_d   = DRAIN_LOAD;
            end
         end
         FEED_DRAIN: begin
            // Last product reaches PE[N-1][N-1] 2N-1 edges after the final beat.
            if (cnt_q == '0) begin
               state_d = FEED_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = FEED_IDLE;
      endcase
      clear_d    = (state_d == FEED_CLEAR);
      in_ready_d = (state_d == FEED_FEED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FEED_IDLE;
         cnt_q      <= '0;
         clear_q    <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clear_q    <= clear_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;
   assign clear    = clear_q;
   assign done     = done_q;
   assign busy     = (state_q != FEED_IDLE);

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_skew_a (
         .clk     (clk),
         .rst_n   (rst_n),
         .din_vld (accept),
         .din_dat (in_a[i*WIDTH +: WIDTH]),
         .dout    (a_edge[i*WIDTH +: WIDTH])
      );
      skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_skew_b (
         .clk     (clk),
         .rst_n   (rst_n),
         .din_vld (accept),
         .din_dat (in_b[i*WIDTH +: WIDTH]),
         .dout    (b_edge[i*WIDTH +: WIDTH])
      );
   end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input skew stage for the N×N output-stationary PE array. Accepts one K-step per beat over a valid/ready handshake: a column of A, N elements, and a row of B, N elements. Delays lane i by i cycles so row-i A data and column-j B data meet in PE[i][j] on the same cycle. Also sequences a job: it pulses the array-wide clear, feeds beats, drains with zeros, and flags when the array's c_out values are final.

## Interface
- WIDTH, 8, element width; matches the PE operand width
- N, 4, array dimension: number of A rows and number of B columns
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request; honoured only in IDLE
- in_a  in  N*WIDTH  A column for this k; element i at bits [i*WIDTH +: WIDTH]
- in_b  in  N*WIDTH  B row for this k; element j at bits [j*WIDTH +: WIDTH]
- in_valid  in  1  beat present
- in_last  in  1  beat is the final k of the job
- in_ready  out  1  beat accepted when in_valid && in_ready
- clear  out  1  drives the clear input of every PE
- a_edge  out  N*WIDTH  lane i feeds a_in of PE[i][0]
- b_edge  out  N*WIDTH  lane j feeds b_in of PE[0][j]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: all PE c_out values final

Reset state: all outputs 0, all skew registers 0, state IDLE.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN.
- IDLE → CLEAR on start. A start in any other state is ignored.
- CLEAR lasts exactly one cycle, with clear=1. Then → FEED.
- FEED: in_ready=1.
  - On an accepted beat, in_a/in_b are pushed into the skew lanes.
  - On a non-accepting cycle (bubble), zeros are pushed into every lane. Alignment is preserved and the products are 0.
  - An accepted beat with in_last=1 → DRAIN, with the drain counter loaded to 2N-2.
- DRAIN: zeros are pushed. The counter decrements each cycle. At 0 → IDLE, with done=1 registered for that transition.
- IDLE and CLEAR push zeros. After any completed job every skew register is 0.
- Skew lane i (A and B alike) is a shift register of depth i+1 that includes the output register. Lane 0 is a single output register.
- No arithmetic. Data passes unmodified, WIDTH bits per element.
- Asynchronous reset mid-job: state → IDLE, lanes zeroed, done/clear/in_ready low. No done is produced for the aborted job.

## Timing
- Beat accepted at edge E: a_edge[i] and b_edge[i] show it during the cycle after edge E+i.
- PE[i][j] accumulates that product at edge E+i+j+1.
- Last beat accepted at edge E: done is high for exactly the cycle following edge E+2N-1. For N=4, that is the cycle following edge E+7.
  - DRAIN occupies edges E+1 .. E+2N-2.
  - The transition to IDLE and the done=1 register both happen at edge E+2N-1.
- clear is high the cycle before in_ready first rises. The PE zeroes its accumulators on that edge, which also absorbs the zeros on the edges.
- Minimum job: start at edge S, CLEAR S+1, FEED from S+1. A single beat with in_last at S+2 gives done after edge S+1+2N.
- in_ready is a pure function of state, with no combinational path from in_valid.
- start and in_valid may arrive in the same cycle while in IDLE; in_valid is not accepted there.
- A start asserted in the same cycle as done is honoured, because the state is IDLE then. Back-to-back jobs are therefore legal.

## Structure
- Shared package/header tpu_pkg:
  - state encodings FEED_IDLE/FEED_CLEAR/FEED_FEED/FEED_DRAIN
  - DRAIN_W = $clog2(2N)
- Sub-module skew_line (params WIDTH, DEPTH ≥ 1): clk, rst_n, zero-or-data in, registered out.
  - Instantiated twice per lane index i, once for A and once for B, with DEPTH=i+1, via generate.
- Top level holds the FSM, drain counter, and registered clear/done/in_ready.

## Test plan
- Reset: drive rst_n=0 mid-DRAIN → all outputs 0 immediately; after release, state IDLE, no done pulse.
- Skew check, N=4: start, one beat in_a={4,3,2,1}, in_b={8,7,6,5}, in_last=1.
  - a_edge[0]=1 one cycle after acceptance, a_edge[3]=4 four cycles after, and 0 elsewhere.
  - b_edge behaves the same way.
  - done exactly 8 cycles after the acceptance edge.
- Full job with a 4×4 PE array attached: A=identity, B rows {1..4},{5..8},{9..12},{13..16}, K=4, no bubbles → at done, PE c_out equals B exactly.
- Bubbles: same job with in_valid low on alternate cycles → identical c_out. done is 2N-1 edges after the last accepted beat.
- Protocol: start during FEED → ignored, and clear does not re-pulse. in_valid before CLEAR finishes → in_ready=0, no acceptance.
- Back-to-back: start in the done cycle → clear pulses next cycle, the second job's results are correct, and no residue from the first job remains.
